// File: rtl/ex_div.sv
// Iterative 32-cycle restoring divider for the EX stage (DIV/DIVU/REM/REMU).
// Operates on operand magnitudes and fixes up signs when the result is written.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cancel,
    input  logic        op_signed,
    input  logic        op_rem,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] result,
    output logic        ready,
    output logic        stallreq
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic [5:0]  count;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic        neg_q;
    logic        neg_r;
    logic        sel_rem;

    logic        div_zero;
    logic        overflow;
    logic        accept;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] q_final;
    logic [31:0] r_final;

    assign div_zero = (divisor == 32'h0);
    assign overflow = op_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
    assign accept   = start && !cancel;
    assign dvd_mag  = (op_signed && dividend[31]) ? -dividend : dividend;
    assign dvs_mag  = (op_signed && divisor[31])  ? -divisor  : divisor;

    // One restoring step: shift the next dividend bit in, keep the difference if it fits.
    assign shifted  = {rem, quo[31]};
    assign trial    = shifted - {1'b0, dvs};
    assign rem_step = trial[32] ? shifted[31:0] : trial[31:0];
    assign quo_step = {quo[30:0], ~trial[32]};
    assign q_final  = neg_q ? -quo_step : quo_step;
    assign r_final  = neg_r ? -rem_step : rem_step;

    assign ready    = (state == DONE);
    assign stallreq = !cancel && (((state == IDLE) && start) || (state == BUSY));

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (div_zero || overflow) ? DONE : BUSY;
            BUSY: if (count == 6'd31) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (cancel) state_next = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= 6'd0;
            result  <= 32'h0;
            quo     <= 32'h0;
            rem     <= 32'h0;
            dvs     <= 32'h0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            sel_rem <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (div_zero) begin
                            result <= op_rem ? dividend : 32'hFFFF_FFFF;
                        end else if (overflow) begin
                            result <= op_rem ? 32'h0 : 32'h8000_0000;
                        end else begin
                            quo     <= dvd_mag;
                            rem     <= 32'h0;
                            dvs     <= dvs_mag;
                            neg_q   <= op_signed && (dividend[31] ^ divisor[31]);
                            neg_r   <= op_signed && dividend[31];
                            sel_rem <= op_rem;
                            count   <= 6'd0;
                        end
                    end
                end
                BUSY: begin
                    if (!cancel) begin
                        quo   <= quo_step;
                        rem   <= rem_step;
                        count <= count + 6'd1;
                        if (count == 6'd31) result <= sel_rem ? r_final : q_final;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 SHALL have clk  input  1  clock; all state changes on rising edge.
REQ-002 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have start  input  1  EX stage issues a divide/remainder op; held high while the pipeline is stalled.
REQ-004 SHALL have cancel  input  1  flush of the in-flight op by a branch or exception.
REQ-005 SHALL have op_signed  input  1  1 = DIV/REM, 0 = DIVU/REMU.
REQ-006 SHALL have op_rem  input  1  1 = return remainder, 0 = return quotient.
REQ-007 SHALL have dividend  input  32  ex_opv1 operand.
REQ-008 SHALL have divisor  input  32  ex_opv2 operand.
REQ-009 SHALL have result  output  32  registered result; valid when ready=1.
REQ-010 SHALL have ready  output  1  registered one-cycle completion pulse.
REQ-011 SHALL have stallreq  output  1  combinational stall request to the stall controller (stage index 3).

Function
REQ-012 SHALL implement states IDLE, BUSY, DONE with a 6-bit iteration counter.
REQ-013 SHALL transition IDLE->BUSY on start=1 & cancel=0 & divisor!=0 & not signed-overflow, latching operands and op flags and clearing the counter.
REQ-014 SHALL transition IDLE->DONE on start=1 & cancel=0 with divisor==0 (fast path): quotient 0xFFFFFFFF, remainder = dividend.
REQ-015 SHALL transition IDLE->DONE on signed overflow (op_signed=1, dividend 0x80000000, divisor 0xFFFFFFFF): quotient 0x80000000, remainder 0.
REQ-016 SHALL perform one restoring shift-subtract step per BUSY cycle on operand magnitudes, 32 steps, counter 0..31; BUSY->DONE on the cycle with counter==31.
REQ-017 SHALL, for signed ops, negate the quotient when the operand signs differ and give the remainder the sign of the dividend; the final result SHALL be written into result on entry to DONE.
REQ-018 SHALL assert ready=1 for exactly the DONE cycle; DONE->IDLE unconditionally on the next edge.
REQ-019 SHALL hold result stable from DONE until the next accepted operation completes; ready=0 outside DONE.
REQ-020 SHALL drive stallreq = (IDLE & start & !cancel) | BUSY; stallreq=0 in DONE so the pipeline advances in that cycle.
REQ-021 SHALL give latency: normal op, start seen at cycle 0, ready at cycle 33; fast-path op, ready at cycle 1.
REQ-022 SHALL treat start in DONE as the same (completed) op and SHALL NOT restart from DONE.
REQ-023 SHALL, on cancel=1, go to IDLE on the next edge from any state, force stallreq=0 combinationally, leave result unchanged, and suppress any ready pulse for the cancelled op.
REQ-024 SHALL ignore operand and op-flag changes during BUSY; the latched values are used.
REQ-025 SHALL treat cancel as having priority over start when both are high in IDLE; no op is accepted.

Reset
REQ-026 SHALL, on rst=1 at an edge, set state IDLE, counter 0, result 0x00000000, ready 0, latched operands 0.
REQ-027 SHALL, on rst during BUSY or DONE, abandon the op with no ready pulse; stallreq=0 in the cycle after the reset edge unless start is high.
REQ-028 SHALL give rst priority over cancel and start.

Verification
REQ-029 SHALL cover: DIVU 100/7 -> stallreq high cycles 0-32, ready at cycle 33, result 14; REMU gives 2.
REQ-030 SHALL cover: DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-031 SHALL cover: DIVU 5/0 -> ready at cycle 1, result 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-032 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> ready at cycle 1, result 0x80000000; REM -> 0.
REQ-033 SHALL cover: cancel at cycle 10 of a BUSY op -> stallreq 0 immediately, IDLE at cycle 11, no ready, result keeps its prior value; a new start then completes normally.
REQ-034 SHALL cover: rst at cycle 20 of a BUSY op -> result 0, ready 0, IDLE; start held high with no rst through DONE -> exactly one ready pulse.
